// File: rtl/inv_gen_sub_key.sv
// inv_gen_sub_key: walks an AES-128 round key backwards from round 10 to a
// requested round, one inverse key-schedule step per clock.
// Optional feature macro: INV_SUBKEY_RANGE_CHK_EN. When defined, a request
// with round_n > 10 is rejected with an err_out pulse. When undefined,
// round_n > 10 is clamped to 10 and err_out is tied low.
//
// Handshake: the request is taken on a rising edge where valid_in=1 and
// ready_out=1 (ready_out is high only in IDLE). valid_in is ignored while
// ready_out=0. The result is presented with valid_out=1 for exactly one
// cycle, and data_out then holds that result until the next one is produced.
module inv_gen_sub_key #(
  parameter int KEY_LEN  = 128,
  parameter int WORD_LEN = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         round_n,
  input  logic [KEY_LEN-1:0] data_in,
  input  logic               valid_in,
  output logic               ready_out,
  output logic [KEY_LEN-1:0] data_out,
  output logic               valid_out,
  output logic               err_out,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_e;

  // Forward AES S-box; entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte b lives at bit offset (255-b)*8, and 255-b equals ~b for 8 bits.
  function automatic logic [WORD_LEN-1:0] sub_word(input logic [WORD_LEN-1:0] w);
    logic [WORD_LEN-1:0] r;
    r = '0;
    for (int i = 0; i < WORD_LEN / 8; i++) begin
      r[i*8 +: 8] = SBOX[{~w[i*8 +: 8], 3'b000} +: 8];
    end
    return r;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  state_e               state_q, state_d;
  logic [KEY_LEN-1:0]   key_q, key_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [3:0]           tgt_q, tgt_d;
  logic [KEY_LEN-1:0]   dout_q, dout_d;
  logic                 vout_q, vout_d;
`ifdef INV_SUBKEY_RANGE_CHK_EN
  logic                 err_q, err_d;
`endif

  logic [WORD_LEN-1:0]  w0, w1, w2, w3;
  logic [WORD_LEN-1:0]  w0_n, w1_n, w2_n, w3_n;
  logic [WORD_LEN-1:0]  rot_w3;
  logic [KEY_LEN-1:0]   step_key;

  // One inverse key-schedule step: round cnt_q key -> round cnt_q-1 key.
  always_comb begin
    w0       = key_q[KEY_LEN-1            -: WORD_LEN];
    w1       = key_q[KEY_LEN-1-WORD_LEN   -: WORD_LEN];
    w2       = key_q[KEY_LEN-1-2*WORD_LEN -: WORD_LEN];
    w3       = key_q[WORD_LEN-1:0];
    w3_n     = w3 ^ w2;
    w2_n     = w2 ^ w1;
    w1_n     = w1 ^ w0;
    rot_w3   = {w3_n[WORD_LEN-9:0], w3_n[WORD_LEN-1 -: 8]};
    w0_n     = w0 ^ sub_word(rot_w3) ^ {rcon(cnt_q), {(WORD_LEN-8){1'b0}}};
    step_key = {w0_n, w1_n, w2_n, w3_n};
  end

  // Next-state and next-output logic for the IDLE/WALK/DONE controller.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    dout_d  = dout_q;
    vout_d  = 1'b0;
`ifdef INV_SUBKEY_RANGE_CHK_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (valid_in) begin
`ifdef INV_SUBKEY_RANGE_CHK_EN
          if (round_n > 4'd10) begin
            err_d = 1'b1;
          end else begin
            key_d   = data_in;
            cnt_d   = 4'd10;
            tgt_d   = round_n;
            state_d = WALK;
          end
`else
          key_d   = data_in;
          cnt_d   = 4'd10;
          tgt_d   = (round_n > 4'd10) ? 4'd10 : round_n;
          state_d = WALK;
`endif
        end
      end
      WALK: begin
        if (cnt_q == tgt_q) begin
          dout_d  = key_q;
          vout_d  = 1'b1;
          state_d = DONE;
        end else begin
          key_d = step_key;
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      dout_q  <= '0;
      vout_q  <= 1'b0;
`ifdef INV_SUBKEY_RANGE_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
`ifdef INV_SUBKEY_RANGE_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign ready_out = (state_q == IDLE);
  assign data_out  = dout_q;
  assign valid_out = vout_q;
  assign state_dbg = state_q;
`ifdef INV_SUBKEY_RANGE_CHK_EN
  assign err_out   = err_q;
`else
  assign err_out   = 1'b0;
`endif

endmodule

// File: tb/tb_inv_gen_sub_key.sv
// Testbench for inv_gen_sub_key: directed vectors from the AES-128 key
// schedule plus hand-written sequences for reset, held valid_in and range.
module tb_inv_gen_sub_key;

  logic         clk;
  logic         reset;
  logic [3:0]   round_n;
  logic [127:0] data_in;
  logic         valid_in;
  logic         ready_out;
  logic [127:0] data_out;
  logic         valid_out;
  logic         err_out;
  logic [1:0]   state_dbg;

  int n_vec;
  int n_fail;

  typedef struct {
    logic [127:0] din;
    logic [3:0]   rn;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[8];

  inv_gen_sub_key #(.KEY_LEN(128), .WORD_LEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .round_n   (round_n),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .err_out   (err_out),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: issue one request, wait for the result, check latency and value.
  task automatic run_op(input logic [127:0] din, input logic [3:0] rn, input logic [127:0] exp);
    int edges;
    int n_exp;
    logic seen;
    logic moved;
    logic [127:0] held;
    n_exp = 10 - ((rn > 4'd10) ? 10 : int'(rn)) + 1;
    @(negedge clk);
    data_in  = din;
    round_n  = rn;
    valid_in = 1'b1;
    held     = data_out;
    @(posedge clk);
    #1;
    @(negedge clk);
    valid_in = 1'b0;
    edges = 0;
    seen  = 1'b0;
    moved = 1'b0;
    while (!seen && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (valid_out) seen = 1'b1;
      else if (data_out !== held) moved = 1'b1;
    end
    check("latency", 128'(edges), 128'(n_exp));
    check("data_out", data_out, exp);
    check("hold_in_walk", 128'(moved), 128'd0);
    check("err_quiet", 128'(err_out), 128'd0);
    @(posedge clk);
    #1;
    check("valid_one_cycle", 128'(valid_out), 128'd0);
    check("ready_after_done", 128'(ready_out), 128'd1);
    check("data_hold", data_out, exp);
  endtask

  initial begin
    int pulses;
    int edges;
    logic [127:0] got;

    n_vec    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    valid_in = 1'b0;
    round_n  = 4'd0;
    data_in  = '0;

    vecs[0] = '{128'h13111d7fe3944a17f307a78b4d2b30c5, 4'd0,  128'h000102030405060708090a0b0c0d0e0f};
    vecs[1] = '{128'h13111d7fe3944a17f307a78b4d2b30c5, 4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
    vecs[2] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[3] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[4] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[5] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    vecs[6] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd9,  128'hac7766f319fadc2128d12941575c006e};
    vecs[7] = '{128'h0123456789abcdeffedcba9876543210, 4'd10, 128'h0123456789abcdeffedcba9876543210};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 128'(ready_out), 128'd1);
    check("rst_valid", 128'(valid_out), 128'd0);
    check("rst_err", 128'(err_out), 128'd0);
    check("rst_data", data_out, 128'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].din, vecs[i].rn, vecs[i].exp);
    end

    // valid_in held high with data_in/round_n changing after acceptance
    @(negedge clk);
    data_in  = vecs[5].din;
    round_n  = vecs[5].rn;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    pulses = 0;
    edges  = 0;
    got    = '0;
    for (int e = 0; e < 25; e++) begin
      @(negedge clk);
      if (pulses == 0) begin
        data_in = {$urandom, $urandom, $urandom, $urandom};
        round_n = 4'($urandom_range(0, 10));
      end else begin
        valid_in = 1'b0;
      end
      @(posedge clk);
      #1;
      if (pulses == 0) edges++;
      if (valid_out) begin
        pulses++;
        got = data_out;
      end
    end
    valid_in = 1'b0;
    check("held_valid_pulses", 128'(pulses), 128'd1);
    check("held_valid_latency", 128'(edges), 128'd6);
    check("held_valid_data", got, vecs[5].exp);

    // Reset in the middle of WALK, asserted together with valid_in
    @(negedge clk);
    data_in  = vecs[2].din;
    round_n  = 4'd0;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset    = 1'b1;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready", 128'(ready_out), 128'd1);
    check("abort_data", data_out, 128'd0);
    check("abort_valid", 128'(valid_out), 128'd0);
    @(negedge clk);
    reset    = 1'b0;
    valid_in = 1'b0;
    pulses   = 0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk);
      #1;
      if (valid_out) pulses++;
    end
    check("abort_no_valid", 128'(pulses), 128'd0);

    // Out-of-range round_n
`ifdef INV_SUBKEY_RANGE_CHK_EN
    @(negedge clk);
    data_in  = vecs[7].din;
    round_n  = 4'd12;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    check("range_err_pulse", 128'(err_out), 128'd1);
    check("range_stays_idle", 128'(ready_out), 128'd1);
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    check("range_err_one_cycle", 128'(err_out), 128'd0);
    pulses = 0;
    for (int e = 0; e < 14; e++) begin
      @(posedge clk);
      #1;
      if (valid_out) pulses++;
    end
    check("range_no_valid", 128'(pulses), 128'd0);
`else
    run_op(vecs[7].din, 4'd12, vecs[7].din);
    run_op(vecs[0].din, 4'd15, vecs[0].din);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
